// File: rtl/am2905_bus_arb_if.sv
// Control and request bundle between the am2905 bus arbiter and its requesters/transceivers.
// The master modport is the arbiter side. The slave modport is the requester/transceiver side.
interface am2905_bus_arb_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      src_sel;
  logic [NREQ*IDXW-1:0] dst;
  logic [NREQ-1:0]      sel;
  logic [NREQ-1:0]      drcp;
  logic [NREQ-1:0]      be_;
  logic [NREQ-1:0]      rle_;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic [IDXW-1:0]      gnt_id;

  modport master (
    input  req, src_sel, dst,
    output sel, drcp, be_, rle_, ack, busy, gnt_id
  );

  modport slave (
    output req, src_sel, dst,
    input  sel, drcp, be_, rle_, ack, busy, gnt_id
  );
endinterface

// File: rtl/am2905_bus_arb.sv
// Round-robin sequencer sharing one open-collector bus among NREQ am2905 transceivers.
// Each grant runs one transfer: SETUP, STROBE, DRIVE (x DRIVE_CYC), CAPTURE, RELEASE.
module am2905_bus_arb #(
  parameter int NREQ      = 4,
  parameter int IDXW      = 2,
  parameter int DRIVE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  am2905_bus_arb_if.master  bus
);
  localparam int DRV = (DRIVE_CYC < 1) ? 1 : DRIVE_CYC;
  localparam int CW  = (DRV > 1) ? $clog2(DRV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, DRIVE, CAPTURE, RELEASE} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] g, g_nx, d, d_nx, ptr, ptr_nx;
  logic            s, s_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [NREQ-1:0] sel_nx, drcp_nx, be_nx, rle_nx, ack_nx;

  // Two-pass rotating priority: lowest requester above ptr, else lowest at/below ptr.
  logic            found_hi, found_lo, s_hi, s_lo;
  logic [IDXW-1:0] win_hi, win_lo, dst_hi, dst_lo;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    dst_hi   = '0;
    dst_lo   = '0;
    s_hi     = 1'b0;
    s_lo     = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (i > int'(ptr)) begin
          found_hi = 1'b1;
          win_hi   = IDXW'(i);
          dst_hi   = bus.dst[i*IDXW +: IDXW];
          s_hi     = bus.src_sel[i];
        end else begin
          found_lo = 1'b1;
          win_lo   = IDXW'(i);
          dst_lo   = bus.dst[i*IDXW +: IDXW];
          s_lo     = bus.src_sel[i];
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    g_nx     = g;
    d_nx     = d;
    s_nx     = s;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (found_hi || found_lo) begin
          state_nx = SETUP;
          g_nx     = found_hi ? win_hi : win_lo;
          d_nx     = found_hi ? dst_hi : dst_lo;
          s_nx     = found_hi ? s_hi   : s_lo;
          ptr_nx   = found_hi ? win_hi : win_lo;
        end
      end
      SETUP:   state_nx = STROBE;
      STROBE: begin
        state_nx = DRIVE;
        cnt_nx   = CW'(DRV - 1);
      end
      DRIVE: begin
        if (cnt == '0) state_nx = CAPTURE;
        else           cnt_nx   = cnt - CW'(1);
      end
      CAPTURE: state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with it.
  always_comb begin
    sel_nx  = '0;
    drcp_nx = '0;
    be_nx   = '1;
    rle_nx  = '1;
    ack_nx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g_nx == IDXW'(i)) begin
        if (state_nx inside {SETUP, STROBE, DRIVE, CAPTURE}) sel_nx[i] = s_nx;
        if (state_nx == STROBE)                  drcp_nx[i] = 1'b1;
        if (state_nx inside {DRIVE, CAPTURE})    be_nx[i]   = 1'b0;
        if (state_nx == RELEASE)                 ack_nx[i]  = 1'b1;
      end
      // An out-of-range destination matches no slice, so no latch opens.
      if (d_nx == IDXW'(i) && state_nx == DRIVE) rle_nx[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      g           <= '0;
      d           <= '0;
      s           <= 1'b0;
      ptr         <= IDXW'(NREQ - 1);
      cnt         <= '0;
      bus.sel     <= '0;
      bus.drcp    <= '0;
      bus.be_     <= '1;
      bus.rle_    <= '1;
      bus.ack     <= '0;
      bus.busy    <= 1'b0;
      bus.gnt_id  <= '0;
    end else begin
      state       <= state_nx;
      g           <= g_nx;
      d           <= d_nx;
      s           <= s_nx;
      ptr         <= ptr_nx;
      cnt         <= cnt_nx;
      bus.sel     <= sel_nx;
      bus.drcp    <= drcp_nx;
      bus.be_     <= be_nx;
      bus.rle_    <= rle_nx;
      bus.ack     <= ack_nx;
      bus.busy    <= (state_nx != IDLE);
      bus.gnt_id  <= g_nx;
    end
  end
endmodule
